// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Instruction issue channel into alu_issue_ctrl (valid/ready handshake).
//   instr_valid : source offers an instruction
//   instr_ready : controller can accept this cycle
//   instr       : 32-bit MIPS R-type word
// Modports:
//   master : instruction source (drives valid/instr)
//   slave  : the controller (drives ready)
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller in front of a funct-coded 32-bit ALU. Accepts
// R-type instructions, reads operands from an internal 32x32 register file,
// holds them on the ALU for ALU_LAT cycles, then writes the ALU result back.
// Ports:
//   clk, reset (async, active-low)
//   ibus        : instruction handshake (slave side)
//   alu_dataA/B, alu_signal, alu_reset : operands/funct/clear to the ALU
//   alu_dataOut : ALU result
//   wb_valid, wb_addr, wb_data : one-cycle writeback strobe
//   err         : one-cycle pulse after a rejected instruction
//   dbg_*       : debug register write (IDLE only) and combinational read
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_issue_ctrl_if.slave        ibus,
    output logic [31:0]            alu_dataA,
    output logic [31:0]            alu_dataB,
    output logic [5:0]             alu_signal,
    output logic                   alu_reset,
    input  logic [31:0]            alu_dataOut,
    output logic                   wb_valid,
    output logic [4:0]             wb_addr,
    output logic [31:0]            wb_data,
    output logic                   err,
    input  logic                   dbg_we,
    input  logic [4:0]             dbg_waddr,
    input  logic [31:0]            dbg_wdata,
    input  logic [4:0]             dbg_raddr,
    output logic [31:0]            dbg_rdata
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic [5:0]  signal_q, signal_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        legal;
    logic        accept;
    logic        unused_shamt;

    assign op           = ibus.instr[31:26];
    assign rs           = ibus.instr[25:21];
    assign rt           = ibus.instr[20:16];
    assign rd           = ibus.instr[15:11];
    assign funct        = ibus.instr[5:0];
    assign unused_shamt = ^ibus.instr[10:6];

    assign legal  = (op == 6'd0) &&
                    (funct == F_ADD || funct == F_SUB || funct == F_AND ||
                     funct == F_OR  || funct == F_SLT);
    // Illegal instructions are "accepted" too: they consume the handshake and
    // block a same-edge debug write, they just never leave IDLE.
    assign accept = (state_q == ST_IDLE) && ibus.instr_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        signal_d  = signal_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        err_d     = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = dbg_waddr;
        rf_wdata  = dbg_wdata;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        data_a_d  = rf_q[rs];
                        data_b_d  = rf_q[rt];
                        signal_d  = funct;
                        wb_addr_d = rd;
                        cnt_d     = 4'd0;
                        state_d   = ST_EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (dbg_we) begin
                    rf_we = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q == LAT_LAST) begin
                    wb_data_d = alu_dataOut;
                    rf_we     = 1'b1;
                    rf_waddr  = wb_addr_q;
                    rf_wdata  = alu_dataOut;
                    state_d   = ST_WB;
                end else begin
                    cnt_d = 4'(cnt_q + 4'd1);
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-register next value; entry 0 never loads, so it stays at its reset 0.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf_next
            if (gi == 0) begin : g_zero
                assign rf_d[gi] = rf_q[gi];
            end else begin : g_reg
                assign rf_d[gi] = (rf_we && rf_waddr == 5'(gi)) ? rf_wdata : rf_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            signal_q  <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            signal_q  <= signal_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign ibus.instr_ready = (state_q == ST_IDLE);
    assign alu_dataA        = data_a_q;
    assign alu_dataB        = data_b_q;
    assign alu_signal       = signal_q;
    assign alu_reset        = (state_q != ST_EXEC);
    assign wb_valid         = (state_q == ST_WB);
    assign wb_addr          = wb_addr_q;
    assign wb_data          = wb_data_q;
    assign err              = err_q;
    assign dbg_rdata        = (dbg_raddr == 5'd0) ? 32'd0 : rf_q[dbg_raddr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Two controllers (ALU_LAT=1 and ALU_LAT=3) share one instruction stream and
// each drives its own behavioural ALU. A transaction-level model (register
// file array + cycles-since-accept count) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] instr     = '0;
    logic [1:0]  valid     = '0;
    logic        dbg_we    = 1'b0;
    logic [4:0]  dbg_waddr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [4:0]  dbg_raddr = '0;
    bit          rand_raddr = 1'b0;

    logic [1:0][31:0] o_a, o_b, o_wbd, o_dbg, alu_out;
    logic [1:0][5:0]  o_sig;
    logic [1:0][4:0]  o_wba;
    logic [1:0]       o_ready, o_areset, o_wbv, o_err;

    int tests = 0;
    int fails = 0;

    alu_issue_ctrl_if if0 ();
    alu_issue_ctrl_if if1 ();
    assign if0.instr       = instr;
    assign if1.instr       = instr;
    assign if0.instr_valid = valid[0];
    assign if1.instr_valid = valid[1];
    assign o_ready[0]      = if0.instr_ready;
    assign o_ready[1]      = if1.instr_ready;

    alu_issue_ctrl #(.ALU_LAT(LAT0)) u_dut0 (
        .clk(clk), .reset(rst_n), .ibus(if0),
        .alu_dataA(o_a[0]), .alu_dataB(o_b[0]), .alu_signal(o_sig[0]), .alu_reset(o_areset[0]),
        .alu_dataOut(alu_out[0]), .wb_valid(o_wbv[0]), .wb_addr(o_wba[0]), .wb_data(o_wbd[0]),
        .err(o_err[0]), .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(o_dbg[0]));

    alu_issue_ctrl #(.ALU_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(rst_n), .ibus(if1),
        .alu_dataA(o_a[1]), .alu_dataB(o_b[1]), .alu_signal(o_sig[1]), .alu_reset(o_areset[1]),
        .alu_dataOut(alu_out[1]), .wb_valid(o_wbv[1]), .wb_addr(o_wba[1]), .wb_data(o_wbd[1]),
        .err(o_err[1]), .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .dbg_raddr(dbg_raddr), .dbg_rdata(o_dbg[1]));

    // Behavioural ALU: SLT returns the smaller (signed) operand value.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
        case (f)
            6'd32:   return a + b;
            6'd34:   return a - b;
            6'd36:   return a & b;
            6'd37:   return a | b;
            6'd42:   return ($signed(a) < $signed(b)) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out[0] = o_areset[0] ? 32'd0 : alu_f(o_a[0], o_b[0], o_sig[0]);
    assign alu_out[1] = o_areset[1] ? 32'd0 : alu_f(o_a[1], o_b[1], o_sig[1]);

    function automatic bit is_legal(input logic [31:0] iw);
        return (iw[31:26] == 6'd0) && (iw[5:0] inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction

    // ---------------- reference model ----------------
    // m_phase: 0 = idle, 1..LAT = operands on ALU, LAT+1 = writeback cycle.
    int          m_phase [2];
    bit [31:0]   m_rf    [2][32];
    bit [31:0]   m_a     [2];
    bit [31:0]   m_b     [2];
    bit [31:0]   m_wbd   [2];
    bit [5:0]    m_sig   [2];
    bit [4:0]    m_wba   [2];
    bit          m_err   [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 32; r++) m_rf[k][r] = '0;
                m_phase[k] = 0; m_a[k] = '0; m_b[k] = '0; m_wbd[k] = '0;
                m_sig[k] = '0; m_wba[k] = '0; m_err[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_err[k] = 1'b0;
                if (m_phase[k] == 0) begin
                    if (valid[k]) begin
                        if (is_legal(instr)) begin
                            m_a[k]     = m_rf[k][instr[25:21]];
                            m_b[k]     = m_rf[k][instr[20:16]];
                            m_sig[k]   = instr[5:0];
                            m_wba[k]   = instr[15:11];
                            m_phase[k] = 1;
                        end else begin
                            m_err[k] = 1'b1;
                        end
                    end else if (dbg_we && dbg_waddr != 5'd0) begin
                        m_rf[k][dbg_waddr] = dbg_wdata;
                    end
                end else begin
                    m_phase[k] = m_phase[k] + 1;
                    if (m_phase[k] == lat_of(k) + 1) begin
                        m_wbd[k] = alu_f(m_a[k], m_b[k], m_sig[k]);
                        if (m_wba[k] != 5'd0) m_rf[k][m_wba[k]] = m_wbd[k];
                    end else if (m_phase[k] > lat_of(k) + 1) begin
                        m_phase[k] = 0;
                    end
                end
            end
        end
    end

    task automatic cmp(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s dut%0d t=%0t got=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    task automatic check_dut(input int k);
        int ph;
        ph = m_phase[k];
        cmp("instr_ready", k, 32'(o_ready[k]),  32'(ph == 0));
        cmp("alu_reset",   k, 32'(o_areset[k]), 32'(!(ph >= 1 && ph <= lat_of(k))));
        cmp("wb_valid",    k, 32'(o_wbv[k]),    32'(ph == lat_of(k) + 1));
        cmp("err",         k, 32'(o_err[k]),    32'(m_err[k]));
        cmp("alu_dataA",   k, o_a[k],           m_a[k]);
        cmp("alu_dataB",   k, o_b[k],           m_b[k]);
        cmp("alu_signal",  k, 32'(o_sig[k]),    32'(m_sig[k]));
        cmp("wb_addr",     k, 32'(o_wba[k]),    32'(m_wba[k]));
        cmp("wb_data",     k, o_wbd[k],         m_wbd[k]);
        cmp("dbg_rdata",   k, o_dbg[k],         m_rf[k][dbg_raddr]);
    endtask

    always @(negedge clk) begin
        check_dut(0);
        check_dut(1);
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
        if (rand_raddr) dbg_raddr = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_phase[0] != 0 || m_phase[1] != 0) && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            tests++; fails++;
            $display("[TB] FAIL idle_timeout t=%0t", $time);
        end
    endtask

    task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
        wait_idle();
        dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
        $display("[TB] t=%0t dbg_write r%0d=%h", $time, a, d);
        step();
        dbg_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] iw, input int hold, input bit with_dbg);
        wait_idle();
        instr = iw;
        valid = 2'b11;
        if (with_dbg) begin
            dbg_we = 1'b1; dbg_waddr = 5'($urandom_range(1, 7)); dbg_wdata = $urandom;
        end
        $display("[TB] t=%0t issue instr=%08h legal=%0d hold=%0d dbg_we=%0d",
                 $time, iw, is_legal(iw), hold, with_dbg);
        repeat (hold) step();
        valid  = 2'b00;
        dbg_we = 1'b0;
        wait_idle();
    endtask

    task automatic lit_result(input string name, input logic [4:0] rd, input logic [31:0] wbd,
                              input logic [31:0] rdval);
        dbg_raddr = rd;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp({name, "_wb_data"}, k, o_wbd[k], wbd);
            cmp({name, "_wb_addr"}, k, 32'(o_wba[k]), 32'(rd));
            cmp({name, "_rf"},      k, o_dbg[k], rdval);
        end
    endtask

    initial begin
        logic [31:0] iw;
        logic [5:0]  f;
        int          sel;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("rst_ready",  k, 32'(o_ready[k]),  32'd1);
            cmp("rst_aluRst", k, 32'(o_areset[k]), 32'd1);
            cmp("rst_wbv",    k, 32'(o_wbv[k]),    32'd0);
        end
        #1 rst_n = 1'b1;

        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd3);
        issue(32'h0022_1820, 1, 1'b0);                 lit_result("add", 5'd3, 32'd8, 32'd8);
        issue(rtype(2, 1, 4, 6'd34), 1, 1'b0);         lit_result("sub", 5'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        issue(rtype(1, 2, 5, 6'd42), 1, 1'b0);         lit_result("slt", 5'd5, 32'd3, 32'd3);
        issue(rtype(1, 2, 6, 6'd36), 1, 1'b0);         lit_result("and", 5'd6, 32'd1, 32'd1);
        issue(rtype(1, 2, 7, 6'd37), 1, 1'b0);         lit_result("or",  5'd7, 32'd7, 32'd7);
        issue(rtype(1, 2, 0, 6'd32), 1, 1'b0);         lit_result("add_r0", 5'd0, 32'd8, 32'd0);

        iw = rtype(1, 2, 3, 6'd32); iw[31:26] = 6'h08;
        issue(iw, 1, 1'b0);
        issue(rtype(1, 2, 3, 6'h27), 2, 1'b0);         lit_result("illegal", 5'd0, 32'd8, 32'd0);
        dbg_raddr = 5'd3; #1;
        for (int k = 0; k < 2; k++) cmp("illegal_r3", k, o_dbg[k], 32'd8);

        issue(rtype(1, 2, 3, 6'd32), 1, 1'b0);         lit_result("dep1", 5'd3, 32'd8, 32'd8);
        issue(rtype(3, 3, 3, 6'd32), 1, 1'b0);         lit_result("dep2", 5'd3, 32'd16, 32'd16);

        rand_raddr = 1'b1;
        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                dbg_write(5'($urandom_range(0, 7)), $urandom);
            end else if (sel == 1) begin
                iw = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'd32);
                if ($urandom_range(0, 1) == 1) begin
                    iw[31:26] = 6'($urandom_range(1, 63));
                end else begin
                    do f = 6'($urandom); while (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42});
                    iw[5:0] = f;
                end
                issue(iw, $urandom_range(1, 2), $urandom_range(0, 1) == 1);
            end else begin
                case ($urandom_range(0, 4))
                    0: f = 6'd32;
                    1: f = 6'd34;
                    2: f = 6'd36;
                    3: f = 6'd37;
                    default: f = 6'd42;
                endcase
                issue(rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), f),
                      1, sel == 2);
            end
            repeat ($urandom_range(0, 2)) step();
        end
        rand_raddr = 1'b0;

        // Abort mid-EXEC: reset lands during the first EXEC cycle of both DUTs.
        dbg_write(5'd1, 32'd5);
        wait_idle();
        instr = rtype(1, 1, 9, 6'd32);
        valid = 2'b11;
        $display("[TB] t=%0t issue instr=%08h then reset mid-EXEC", $time, instr);
        step();
        valid = 2'b00;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("abort_ready", k, 32'(o_ready[k]), 32'd1);
            cmp("abort_wbv",   k, 32'(o_wbv[k]),   32'd0);
            cmp("abort_aluA",  k, o_a[k],          32'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (LAT1 + 2) step();
        for (int r = 0; r < 32; r++) begin
            dbg_raddr = 5'(r);
            #1;
            for (int k = 0; k < 2; k++) cmp("post_reset_rf", k, o_dbg[k], 32'd0);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
